spi_byte_master: RTL and testbench

- SPI initiator that serializes one byte per handshake onto nss/sck/mosi and captures miso into a received byte.
- It is the master-side counterpart of the CoreLogic MCU SPI slave port, used to drive CoreLogic from on-chip logic.
- It also serves as the bus driver for the serial-RAM and coprocessor SPI links.
- Mode 0, LSB first: mosi is set while sck is low, and the slave samples on the sck rising edge.

---
 rtl/spi_byte_master_pkg.sv | 22 ++
 rtl/spi_phase_counter.sv | 37 +++
 rtl/spi_byte_master.sv | 195 +++++++++++++++++++
 tb/tb_spi_byte_master.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_master_pkg.sv
// Shared types and helpers for the SPI byte master.
// State encoding and default sizing live here.
package spi_byte_master_pkg;

    localparam int unsigned DEF_BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_TRAIL = 3'd4,
        ST_DONE  = 3'd5,
        ST_HOLD  = 3'd6
    } spi_state_e;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/spi_phase_counter.sv
// Loadable down-counter that flags its terminal (zero) count.
// Reloaded by the master on every state change.
module spi_phase_counter
    import spi_byte_master_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0, LSB-first SPI initiator moving one byte per handshake.
// All pins are registered from the next state, so they align with state_q.
module spi_byte_master
    import spi_byte_master_pkg::*;
#(
    parameter int unsigned BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  cs_hold,
    output logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  nss,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned IW = cnt_width(BYTE_WIDTH);
    localparam int unsigned MAXPH = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned PW = cnt_width(MAXPH);
    localparam logic [PW-1:0] DIV_LD = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GAP_LD = PW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(BYTE_WIDTH - 1);
    // With no guard cycles the LEAD/TRAIL phases are bypassed entirely.
    localparam spi_state_e FIRST_ST = spi_state_e'((GAP_CYCLES == 0) ? ST_LOW : ST_LEAD);
    localparam spi_state_e END_ST = spi_state_e'((GAP_CYCLES == 0) ? ST_DONE : ST_TRAIL);

    spi_state_e state_q;
    spi_state_e state_d;

    logic [BYTE_WIDTH-1:0] tx_q, tx_d;
    logic [BYTE_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [BYTE_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [IW-1:0] bit_q, bit_d;
    logic hold_q, hold_d;
    logic nss_q, nss_d;
    logic sck_q, sck_d;
    logic mosi_q, mosi_d;
    logic ready_q, ready_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;

    logic accept;
    logic ph_tc;
    logic ph_load;
    logic [PW-1:0] ph_val;

    assign accept = tx_valid && ready_q;
    assign ph_load = (state_d != state_q);
    assign ph_val = (state_d == ST_LEAD || state_d == ST_TRAIL) ? GAP_LD : DIV_LD;

    spi_phase_counter #(
        .W (PW)
    ) u_phase (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .tc_o       (ph_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = FIRST_ST;
            end
            ST_LEAD: begin
                if (ph_tc) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (ph_tc) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (ph_tc) state_d = (bit_q == LAST_BIT) ? END_ST : ST_LOW;
            end
            ST_TRAIL: begin
                if (ph_tc) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!hold_q) state_d = ST_IDLE;
                else if (accept) state_d = FIRST_ST;
                else state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept) state_d = FIRST_ST;
                else if (!tx_valid && !cs_hold) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d = tx_q;
        hold_d = hold_q;
        bit_d = bit_q;
        rx_sr_d = rx_sr_q;
        rx_data_d = rx_data_q;
        if (accept) begin
            tx_d = tx_data;
            hold_d = cs_hold;
            bit_d = '0;
        end
        if (state_q == ST_HIGH && ph_tc && bit_q != LAST_BIT) begin
            bit_d = bit_q + 1'b1;
        end
        // Capture on the edge that raises sck, matching the slave's sample point.
        if (state_q == ST_LOW && ph_tc) begin
            rx_sr_d[bit_q] = miso;
        end
        if (state_d == ST_DONE) begin
            rx_data_d = rx_sr_q;
        end

        nss_d = 1'b0;
        sck_d = 1'b0;
        mosi_d = mosi_q;
        ready_d = 1'b0;
        valid_d = 1'b0;
        busy_d = 1'b1;
        unique case (state_d)
            ST_IDLE: begin
                nss_d = 1'b1;
                mosi_d = 1'b0;
                ready_d = 1'b1;
                busy_d = 1'b0;
            end
            ST_LEAD, ST_LOW: mosi_d = tx_d[bit_d];
            ST_HIGH: sck_d = 1'b1;
            ST_TRAIL: ;
            ST_DONE: begin
                valid_d = 1'b1;
                nss_d = !hold_d;
                ready_d = hold_d;
            end
            ST_HOLD: begin
                ready_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q <= '0;
            rx_sr_q <= '0;
            rx_data_q <= '0;
            bit_q <= '0;
            hold_q <= 1'b0;
            nss_q <= 1'b1;
            sck_q <= 1'b0;
            mosi_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            tx_q <= tx_d;
            rx_sr_q <= rx_sr_d;
            rx_data_q <= rx_data_d;
            bit_q <= bit_d;
            hold_q <= hold_d;
            nss_q <= nss_d;
            sck_q <= sck_d;
            mosi_q <= mosi_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q <= busy_d;
        end
    end

    assign tx_ready = ready_q;
    assign rx_data = rx_data_q;
    assign rx_valid = valid_q;
    assign busy = busy_q;
    assign nss = nss_q;
    assign sck = sck_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: default timing plus a
// CLK_DIV=1 / GAP_CYCLES=0 instance.
module tb_spi_byte_master;

    localparam int BW = 8;
    localparam int DIV = 2;
    localparam int GAP = 2;
    localparam int LAT = 1 + 2 * GAP + 2 * BW * DIV;
    localparam int F_LAT = 1 + 2 * BW * 1;

    logic clk = 1'b0;
    logic reset;
    int cyc = 0;

    logic [7:0] tx_data;
    logic tx_valid, tx_ready, cs_hold;
    logic [7:0] rx_data;
    logic rx_valid, busy, nss, sck, mosi, miso;
    logic inv;

    logic [7:0] f_tx_data;
    logic f_tx_valid, f_tx_ready, f_cs_hold;
    logic [7:0] f_rx_data;
    logic f_rx_valid, f_busy, f_nss, f_sck, f_mosi, f_miso;

    assign miso = mosi ^ inv;
    assign f_miso = 1'b1;

    spi_byte_master #(
        .BYTE_WIDTH (BW),
        .CLK_DIV    (DIV),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cs_hold  (cs_hold),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .nss      (nss),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso)
    );

    spi_byte_master #(
        .BYTE_WIDTH (BW),
        .CLK_DIV    (1),
        .GAP_CYCLES (0)
    ) dut_fast (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (f_tx_data),
        .tx_valid (f_tx_valid),
        .tx_ready (f_tx_ready),
        .cs_hold  (f_cs_hold),
        .rx_data  (f_rx_data),
        .rx_valid (f_rx_valid),
        .busy     (f_busy),
        .nss      (f_nss),
        .sck      (f_sck),
        .mosi     (f_mosi),
        .miso     (f_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int nbits = 0;
    int rx_count = 0;
    int nss_rises = 0;
    int lowrun = 0;
    int last_low = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: serial bit collector and scoreboard consumer.
    initial begin
        logic [7:0] mbyte;
        logic sck_p, nss_p;
        exp_t e;
        mbyte = 0;
        sck_p = 0;
        nss_p = 1;
        forever begin
            @(negedge clk);
            if (reset) begin
                nbits = 0;
                mbyte = 0;
                sck_p = 0;
                nss_p = 1;
                lowrun = 0;
            end else begin
                if (sck && !sck_p) begin
                    chk("nss_during_sck", nss, 0);
                    if (nbits < 8) mbyte[nbits] = mosi;
                    nbits++;
                end
                if (rx_valid) begin
                    rx_count++;
                    if (sb.size() == 0) begin
                        chk("unexpected_rx_valid", rx_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rx_data", rx_data, e.rx);
                        chk("rx_latency", cyc, e.cyc);
                        chk("mosi_byte", mbyte, e.tx);
                        chk("sck_edges", nbits, 8);
                        chk("busy_in_done", busy, 1);
                    end
                    nbits = 0;
                    mbyte = 0;
                end
                if (!nss) begin
                    lowrun++;
                end else if (!nss_p) begin
                    last_low = lowrun;
                    lowrun = 0;
                    nss_rises++;
                end
                sck_p = sck;
                nss_p = nss;
            end
        end
    end

    // Must be called at negedge+1; returns at negedge+1 after the accept edge.
    task automatic send(input logic [7:0] d, input logic h, input logic iv, input bit keep);
        int n;
        exp_t e;
        tx_data = d;
        cs_hold = h;
        inv = iv;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready) begin
            if (n > 300) begin
                chk("accept_timeout", tx_ready, 1);
                tx_valid = 1'b0;
                return;
            end
            n++;
            @(negedge clk);
            #1;
        end
        e.tx = d;
        e.rx = d ^ {8{iv}};
        e.cyc = cyc + LAT;
        sb.push_back(e);
        @(negedge clk);
        #1;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_bits(input int want, input logic want_sck);
        int n;
        n = 0;
        while (!(nbits == want && sck == want_sck) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("wait_bits_timeout", nbits, want);
    endtask

    initial begin
        int r0, c0, acc, n, rises, ones;
        logic [7:0] d;
        logic h, iv, fsck_p;
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        cs_hold = 1'b0;
        inv = 1'b1;
        f_tx_valid = 1'b0;
        f_tx_data = '0;
        f_cs_hold = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;

        chk("rst_nss", nss, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);

        // Single byte, miso = ~mosi
        send(8'h41, 1'b0, 1'b1, 1'b0);
        drain(100);
        idle(2);
        chk("single_nss_low", last_low, LAT - 1);
        chk("single_nss_idle", nss, 1);

        // Three-byte frame, each next byte waiting for the DONE cycle
        r0 = nss_rises;
        send(8'h29, 1'b1, 1'b1, 1'b1);
        send(8'h2A, 1'b1, 1'b1, 1'b1);
        send(8'h32, 1'b0, 1'b1, 1'b0);
        drain(200);
        idle(2);
        chk("frame_nss_rises", nss_rises - r0, 1);
        chk("frame_nss_low", last_low, 3 * LAT - 1);

        // Request while busy must be ignored
        c0 = rx_count;
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        wait_bits(4, 1'b1);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        chk("busy_tx_ready", tx_ready, 0);
        idle(1);
        tx_valid = 1'b0;
        drain(100);
        idle(40);
        chk("busy_single_rx", rx_count - c0, 1);

        // Reset in LOW of bit 5
        send(8'hFF, 1'b0, 1'b1, 1'b0);
        wait_bits(5, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("midrst_nss", nss, 1);
        chk("midrst_sck", sck, 0);
        chk("midrst_mosi", mosi, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_rx_valid", rx_valid, 0);
        sb.delete();
        c0 = rx_count;
        idle(60);
        chk("midrst_no_rx", rx_count - c0, 0);

        // Hold nss across idle cycles, then release
        send(8'h77, 1'b1, 1'b0, 1'b0);
        drain(100);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("hold_nss", nss, 0);
            chk("hold_sck", sck, 0);
            chk("hold_tx_ready", tx_ready, 1);
        end
        cs_hold = 1'b0;
        idle(1);
        chk("hold_release_nss", nss, 1);
        idle(2);

        // Random bytes, holds and miso polarity
        repeat (24) begin
            d = 8'($urandom);
            h = 1'($urandom_range(0, 1));
            iv = 1'($urandom_range(0, 1));
            send(d, h, iv, 1'b0);
            drain(100);
            idle($urandom_range(0, 3));
        end
        cs_hold = 1'b0;
        idle(4);
        chk("rand_end_nss", nss, 1);

        // Fast instance: CLK_DIV=1, no guard phases
        chk("fast_tx_ready", f_tx_ready, 1);
        f_tx_data = 8'h00;
        f_tx_valid = 1'b1;
        acc = cyc;
        idle(1);
        f_tx_valid = 1'b0;
        n = 0;
        rises = 0;
        ones = 0;
        fsck_p = 1'b0;
        while (!f_rx_valid && n < 100) begin
            if (f_sck && !fsck_p) rises++;
            if (f_mosi) ones++;
            fsck_p = f_sck;
            idle(1);
            n++;
        end
        chk("fast_latency", cyc - acc, F_LAT);
        chk("fast_rx_data", f_rx_data, 8'hFF);
        chk("fast_sck_edges", rises, 8);
        chk("fast_mosi_ones", ones, 0);
        idle(1);
        chk("fast_nss_idle", f_nss, 1);

        idle(5);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
